lsu_memory: RTL and testbench

- Parametrised byte-addressed data memory for the RISC-V core's MEM stage.
- Decodes RISC-V load/store funct3 internally: LB/LH/LW/LBU/LHU, SB/SH/SW.
- Uses a valid/ready request handshake with a registered 1-cycle load response.
- After reset, a sequential clear FSM zeroes the array, replacing the single-cycle bulk clear of the previous generation.

---
 rtl/lsu_pkg.sv | 41 ++++
 rtl/lsu_load_ext.sv | 35 +++
 rtl/lsu_memory.sv | 193 +++++++++++++++++++
 tb/tb_lsu_memory.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, the
// clear/idle state type and small address-check helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    // Halfword accesses need addr[0]=0, word accesses need addr[1:0]=0.
    function automatic logic is_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] addr_lo);
        logic mis;
        case (funct3)
            F3_H, F3_HU: mis = addr_lo[0];
            F3_W:        mis = (addr_lo != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Clear the offending low address bits so the access lands on its
    // natural boundary instead of trapping.
    function automatic logic [1:0] align_lo(input logic [2:0] funct3,
                                            input logic [1:0] addr_lo);
        logic [1:0] lo;
        case (funct3)
            F3_H, F3_HU: lo = {addr_lo[1], 1'b0};
            F3_W:        lo = 2'b00;
            default:     lo = addr_lo;
        endcase
        return lo;
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Load data lane select and sign/zero extension. Purely combinational so
// it can sit behind any registered word source (data memory or cache).
module lsu_load_ext
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Pick the addressed byte/halfword and extend according to funct3.
    always_comb begin
        case (i_addr_lo)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
        o_data = '0;
        case (i_funct3)
            F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_data = {24'd0, w_byte};
            F3_H:    o_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_data = {16'd0, w_half};
            F3_W:    o_data = i_word;
            default: o_data = '0;
        endcase
    end

endmodule

// File: rtl/lsu_memory.sv
// Byte-addressed data memory for the MEM stage with RISC-V load/store
// decode, valid/ready requests and a registered one-cycle load response.
// After reset a sequential FSM zeroes one word per cycle (INIT_CLEAR=1).
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned accesses are flagged on
// o_misaligned and suppressed; without it the low bits are forced to the
// natural boundary and the access proceeds.
module lsu_memory
    import lsu_pkg::*;
#(
    parameter int ADDR_W     = 11,
    parameter bit INIT_CLEAR = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req,
    output logic              o_ready,
    input  logic              i_we,
    input  logic [2:0]        i_funct3,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic              o_rvalid,
    output logic [31:0]       o_rdata,
    output logic              o_misaligned
);

    localparam int IDX_W = ADDR_W - 2;
    localparam int DEPTH = 2 ** IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = '1;

    logic [31:0] r_mem [DEPTH];

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_clr_cnt;
    logic [IDX_W-1:0] w_clr_cnt_nxt;
    logic             w_ready;
    logic             w_clr_we;

    logic             w_accept;
    logic             w_store;
    logic             w_load;
    logic             w_mis;
    logic             w_st_legal;
    logic [1:0]       w_lo;
    logic [IDX_W-1:0] w_idx;
    logic [3:0]       w_st_be;
    logic [31:0]      w_st_data;

    logic [3:0]       w_mem_be;
    logic [IDX_W-1:0] w_mem_idx;
    logic [31:0]      w_mem_wdata;

    logic             r_rvalid;
    logic             r_mis;
    logic             r_zero;
    logic [31:0]      r_rword;
    logic [2:0]       r_f3;
    logic [1:0]       r_lo;
    logic [31:0]      w_ext;

    // State register and clear counter; reset restarts the clear sweep.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= INIT_CLEAR ? S_CLEAR : S_IDLE;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    // Clear sweeps one word per cycle and holds off requests until done.
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        w_ready       = 1'b0;
        w_clr_we      = 1'b0;
        case (r_state)
            S_CLEAR: begin
                w_clr_we      = 1'b1;
                w_clr_cnt_nxt = r_clr_cnt + 1'b1;
                if (r_clr_cnt == LAST_IDX) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                w_ready = 1'b1;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign o_ready = w_ready;

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_mis = is_misaligned(i_funct3, i_addr[1:0]);
    assign w_lo  = i_addr[1:0];
`else
    assign w_mis = 1'b0;
    assign w_lo  = align_lo(i_funct3, i_addr[1:0]);
`endif

    assign w_idx      = i_addr[ADDR_W-1:2];
    assign w_accept   = i_req && w_ready && !i_reset;
    assign w_store    = w_accept && i_we;
    assign w_load     = w_accept && !i_we;
    assign w_st_legal = (i_funct3 == F3_B) || (i_funct3 == F3_H) || (i_funct3 == F3_W);

    // Store byte enables and lane-replicated data; illegal or trapped
    // stores produce no enables.
    always_comb begin
        w_st_be   = 4'b0000;
        w_st_data = i_wdata;
        case (i_funct3)
            F3_B: begin
                w_st_be   = 4'b0001 << w_lo;
                w_st_data = {4{i_wdata[7:0]}};
            end
            F3_H: begin
                w_st_be   = w_lo[1] ? 4'b1100 : 4'b0011;
                w_st_data = {2{i_wdata[15:0]}};
            end
            F3_W: begin
                w_st_be   = 4'b1111;
            end
            default: begin
                w_st_be   = 4'b0000;
            end
        endcase
        if (w_mis) begin
            w_st_be = 4'b0000;
        end
    end

    // Single write port shared by the clear sweep and accepted stores.
    always_comb begin
        w_mem_be    = 4'b0000;
        w_mem_idx   = w_idx;
        w_mem_wdata = w_st_data;
        if (w_clr_we && !i_reset) begin
            w_mem_be    = 4'b1111;
            w_mem_idx   = r_clr_cnt;
            w_mem_wdata = '0;
        end else if (w_store) begin
            w_mem_be    = w_st_be;
        end
    end

    // Byte-enabled memory array write.
    always_ff @(posedge i_clk) begin
        for (int b = 0; b < 4; b++) begin
            if (w_mem_be[b]) begin
                r_mem[w_mem_idx][8*b +: 8] <= w_mem_wdata[8*b +: 8];
            end
        end
    end

    // Load response registers: word, funct3 and lane captured on accept,
    // held until the next load so o_rdata stays stable between responses.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rvalid <= 1'b0;
            r_mis    <= 1'b0;
            r_zero   <= 1'b0;
            r_rword  <= '0;
            r_f3     <= F3_W;
            r_lo     <= 2'b00;
        end else begin
            r_rvalid <= w_load;
            r_mis    <= (w_load && w_mis) || (w_store && w_mis && w_st_legal);
            if (w_load) begin
                r_rword <= r_mem[w_idx];
                r_f3    <= i_funct3;
                r_lo    <= w_lo;
                r_zero  <= w_mis;
            end
        end
    end

    lsu_load_ext u_load_ext (
        .i_word    (r_rword),
        .i_funct3  (r_f3),
        .i_addr_lo (r_lo),
        .o_data    (w_ext)
    );

    assign o_rvalid     = r_rvalid;
    assign o_rdata      = r_zero ? 32'd0 : w_ext;
    assign o_misaligned = r_mis;

endmodule

// File: tb/tb_lsu_memory.sv
// Self-checking bench for lsu_memory: directed vector table, reset/clear
// sequences and randomized traffic against a byte-array reference model.
module tb_lsu_memory;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        ready;
    logic        we;
    logic [2:0]  f3;
    logic [10:0] addr;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;
    logic        mis;

    always #5 clk = ~clk;

    lsu_memory #(.ADDR_W(11), .INIT_CLEAR(1'b1)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_req        (req),
        .o_ready      (ready),
        .i_we         (we),
        .i_funct3     (f3),
        .i_addr       (addr),
        .i_wdata      (wdata),
        .o_rvalid     (rvalid),
        .o_rdata      (rdata),
        .o_misaligned (mis)
    );

    int errors = 0;
    int checks = 0;
    logic [7:0]  mdl [2048];
    logic [31:0] last_rdata;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [10:0] addr;
        logic [31:0] wd;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t tbl [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int f3_size(input logic [2:0] fn);
        case (fn)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] fn, input int a, output logic m);
        int sz;
        int base;
        logic [31:0] v;
        logic [31:0] msk;
        sz = f3_size(fn);
        m = 1'b0;
        if (sz == 0) return 32'd0;
        m = (a % sz) != 0;
        if (m && TRAP) return 32'd0;
        base = a - (a % sz);
        v = 32'd0;
        for (int i = 0; i < sz; i++) v = v | (32'(mdl[base + i]) << (8 * i));
        if (!fn[2] && sz < 4 && v[8*sz-1]) begin
            msk = (32'd1 << (8 * sz)) - 32'd1;
            v = v | ~msk;
        end
        return v;
    endfunction

    task automatic ref_store(input logic [2:0] fn, input int a, input logic [31:0] wd, output logic m);
        int sz;
        int base;
        m = 1'b0;
        if (fn > 3'b010) return;
        sz = f3_size(fn);
        m = (a % sz) != 0;
        if (m && TRAP) return;
        base = a - (a % sz);
        for (int i = 0; i < sz; i++) mdl[base + i] = wd[8*i +: 8];
    endtask

    // One request issued at a negedge; response sampled at the next negedge.
    task automatic op(input logic w, input logic [2:0] fn, input logic [10:0] a,
                      input logic [31:0] wd, input string name);
        logic        m;
        logic        ev;
        logic [31:0] ed;
        if (w) begin
            ref_store(fn, int'(a), wd, m);
            ev = 1'b0;
            ed = last_rdata;
        end else begin
            ed = ref_load(fn, int'(a), m);
            ev = 1'b1;
        end
        req = 1'b1; we = w; f3 = fn; addr = a; wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        check($sformatf("%s rvalid", name), 32'(rvalid), 32'(ev));
        check($sformatf("%s rdata", name), rdata, ed);
        check($sformatf("%s misaligned", name), 32'(mis), 32'(TRAP && m));
        last_rdata = ed;
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!ready && n < 3000) begin
            n++;
            @(negedge clk);
        end
        check(name, 32'(n), 32'd512);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 2048; i++) mdl[i] = 8'h00;
        last_rdata = 32'd0;
    endtask

    initial begin
        tbl[0]  = '{1'b0, 3'b010, 11'h7FC, 32'h0,        32'h00000000, "LW 7FC cleared"};
        tbl[1]  = '{1'b1, 3'b010, 11'h010, 32'hDEADBEEF, 32'h0,        "SW 10"};
        tbl[2]  = '{1'b0, 3'b000, 11'h013, 32'h0,        32'hFFFFFFDE, "LB 13"};
        tbl[3]  = '{1'b0, 3'b100, 11'h013, 32'h0,        32'h000000DE, "LBU 13"};
        tbl[4]  = '{1'b0, 3'b001, 11'h012, 32'h0,        32'hFFFFDEAD, "LH 12"};
        tbl[5]  = '{1'b0, 3'b101, 11'h010, 32'h0,        32'h0000BEEF, "LHU 10"};
        tbl[6]  = '{1'b1, 3'b010, 11'h020, 32'h11223344, 32'h0,        "SW 20"};
        tbl[7]  = '{1'b1, 3'b000, 11'h021, 32'h00000055, 32'h0,        "SB 21"};
        tbl[8]  = '{1'b0, 3'b010, 11'h020, 32'h0,        32'h11225544, "LW 20"};
        tbl[9]  = '{1'b1, 3'b010, 11'h040, 32'hA5A5A5A5, 32'h0,        "SW 40"};
        tbl[10] = '{1'b0, 3'b010, 11'h040, 32'h0,        32'hA5A5A5A5, "LW 40 b2b"};

        rst = 1'b1; req = 1'b0; we = 1'b0; f3 = 3'b000; addr = '0; wdata = '0;
        clear_model();
        repeat (3) @(negedge clk);
        check("reset ready", 32'(ready), 32'd0);
        check("reset rvalid", 32'(rvalid), 32'd0);
        check("reset rdata", rdata, 32'd0);
        check("reset misaligned", 32'(mis), 32'd0);
        rst = 1'b0;
        wait_ready("clear length");

        // Directed vectors; stores and loads run back-to-back.
        for (int i = 0; i < 11; i++) begin
            op(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, tbl[i].name);
            if (!tbl[i].we) check($sformatf("%s const", tbl[i].name), rdata, tbl[i].exp);
        end

        // Store leaves the previous load data on o_rdata.
        op(1'b1, 3'b010, 11'h044, 32'h01020304, "SW 44 hold");

        // Misaligned word load.
        op(1'b0, 3'b010, 11'h042, 32'h0, "LW 42 misaligned");
        check("LW 42 const", rdata, TRAP ? 32'h0 : 32'hA5A5A5A5);
        check("LW 42 flag const", 32'(mis), TRAP ? 32'd1 : 32'd0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            logic [10:0] ra;
            ra = ($urandom_range(0, 3) == 0) ? 11'(11'h7C0 + $urandom_range(0, 63))
                                             : 11'($urandom_range(0, 63));
            op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, $urandom, "rand");
            if ($urandom_range(0, 4) == 0) begin
                @(negedge clk);
                check("idle rvalid", 32'(rvalid), 32'd0);
            end
        end

        // Reset arriving while a load response is pending.
        req = 1'b1; we = 1'b0; f3 = 3'b010; addr = 11'h040;
        @(posedge clk);
        #1;
        req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("pending rvalid", 32'(rvalid), 32'd1);
        @(negedge clk);
        check("reset kills rvalid", 32'(rvalid), 32'd0);
        check("reset clears rdata", rdata, 32'd0);
        rst = 1'b0;
        clear_model();

        // Reset in the middle of the clear sweep restarts it.
        repeat (100) @(negedge clk);
        check("mid clear ready", 32'(ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_ready("restarted clear length");
        op(1'b0, 3'b010, 11'h040, 32'h0, "LW 40 after clear");
        op(1'b0, 3'b010, 11'h010, 32'h0, "LW 10 after clear");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
